// File: rtl/mips_mem_arbiter.sv
// Two-master arbiter for the unified MIPS memory: port 0 is the CPU, port 1 the loader/debug master.
// Each access is sequenced IDLE -> ISSUE -> WAIT (MEM_LAT cycles) -> DONE and ends in a one-cycle ack.
module mips_mem_arbiter #(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int MEM_LAT  = 1,
  parameter int CPU_PRIO = 0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic [DW-1:0] m0_rdata,
  output logic          m0_ack,
  output logic          m0_stall,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic [DW-1:0] m1_rdata,
  output logic          m1_ack,
  output logic          m1_stall,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic [1:0]    grant
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  localparam logic [3:0] LAT_LOAD = 4'(MEM_LAT);

  state_t        r_state;
  state_t        w_next_state;
  logic [1:0]    r_grant;
  logic          r_last_grant;
  logic          r_we;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  logic [3:0]    r_cnt;
  logic [DW-1:0] r_m0_rdata;
  logic [DW-1:0] r_m1_rdata;
  logic          w_any_req;
  logic          w_winner;
  logic          w_cnt_last;

  // On a tie the port that did not own the previous transaction wins, unless the CPU has priority.
  always_comb begin
    w_any_req  = m0_req | m1_req;
    w_cnt_last = (r_cnt == 4'd1);
    if (m0_req && m1_req) begin
      w_winner = (CPU_PRIO != 0) ? 1'b0 : ~r_last_grant;
    end else begin
      w_winner = ~m0_req;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_any_req) w_next_state = ISSUE;
      ISSUE:   w_next_state = WAIT;
      WAIT:    if (w_cnt_last) w_next_state = DONE;
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Requester inputs are captured only in IDLE, so later changes cannot disturb the access.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_grant      <= 2'b00;
      r_last_grant <= 1'b1;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_cnt        <= 4'd0;
      r_m0_rdata   <= '0;
      r_m1_rdata   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any_req) begin
            r_grant <= w_winner ? 2'b10 : 2'b01;
            r_we    <= w_winner ? m1_we : m0_we;
            r_addr  <= w_winner ? m1_addr : m0_addr;
            r_wdata <= w_winner ? m1_wdata : m0_wdata;
          end
        end
        ISSUE: r_cnt <= LAT_LOAD;
        WAIT: begin
          r_cnt <= r_cnt - 4'd1;
          if (w_cnt_last && !r_we) begin
            if (r_grant[0]) begin
              r_m0_rdata <= mem_rdata;
            end else begin
              r_m1_rdata <= mem_rdata;
            end
          end
        end
        DONE: begin
          r_last_grant <= r_grant[1];
          r_grant      <= 2'b00;
        end
        default: ;
      endcase
    end
  end

  assign mem_en    = (r_state == ISSUE);
  assign mem_we    = (r_state == ISSUE) & r_we;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign grant     = r_grant;
  assign m0_ack    = (r_state == DONE) & r_grant[0];
  assign m1_ack    = (r_state == DONE) & r_grant[1];
  assign m0_stall  = m0_req & ~m0_ack;
  assign m1_stall  = m1_req & ~m1_ack;
  assign m0_rdata  = r_m0_rdata;
  assign m1_rdata  = r_m1_rdata;

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Bench for mips_mem_arbiter: four instances (MEM_LAT 1/3/15, plus CPU_PRIO=1) each with a
// small latency-accurate memory model; table-driven single transactions plus tie/reset/stale sequences.
module tb_mips_mem_arbiter;

  localparam int N = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0Req[N], m0We[N], m1Req[N], m1We[N];
  logic [31:0] m0Addr[N], m0Wdata[N], m1Addr[N], m1Wdata[N];
  logic [31:0] m0Rdata[N], m1Rdata[N];
  logic        m0Ack[N], m1Ack[N], m0Stall[N], m1Stall[N];
  logic        memEn[N], memWe[N];
  logic [31:0] memAddr[N], memWdata[N], memRdata[N];
  logic [1:0]  grant[N];
  logic [31:0] expRd[N][2];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  function automatic int latOf(int g);
    return (g == 1) ? 3 : ((g == 2) ? 15 : 1);
  endfunction

  function automatic logic [31:0] memDefault(logic [31:0] a);
    return (a == 32'h10) ? 32'h8C08_0004 : (32'hA500_0000 | a);
  endfunction

  for (genvar g = 0; g < N; g++) begin : gInst
    logic [31:0] mem[64];
    bit          wr[64];
    int          cnt = 0;
    logic [5:0]  rdIdx = 6'd0;

    mips_mem_arbiter #(
      .AW(32), .DW(32),
      .MEM_LAT(g == 1 ? 3 : (g == 2 ? 15 : 1)),
      .CPU_PRIO(g == 3 ? 1 : 0)
    ) dut (
      .clk(clk), .reset(reset),
      .m0_req(m0Req[g]), .m0_we(m0We[g]), .m0_addr(m0Addr[g]), .m0_wdata(m0Wdata[g]),
      .m0_rdata(m0Rdata[g]), .m0_ack(m0Ack[g]), .m0_stall(m0Stall[g]),
      .m1_req(m1Req[g]), .m1_we(m1We[g]), .m1_addr(m1Addr[g]), .m1_wdata(m1Wdata[g]),
      .m1_rdata(m1Rdata[g]), .m1_ack(m1Ack[g]), .m1_stall(m1Stall[g]),
      .mem_en(memEn[g]), .mem_we(memWe[g]), .mem_addr(memAddr[g]), .mem_wdata(memWdata[g]),
      .mem_rdata(memRdata[g]), .grant(grant[g])
    );

    // Read data is driven only in the single cycle MEM_LAT after mem_en; all-ones otherwise.
    always @(posedge clk) begin
      if (memEn[g]) begin
        if (memWe[g]) begin
          mem[memAddr[g][7:2]] <= memWdata[g];
          wr[memAddr[g][7:2]]  <= 1'b1;
        end
        cnt   <= latOf(g);
        rdIdx <= memAddr[g][7:2];
      end else if (cnt > 0) begin
        cnt <= cnt - 1;
      end
    end

    assign memRdata[g] = (cnt == 1) ? (wr[rdIdx] ? mem[rdIdx] : memDefault({24'h0, rdIdx, 2'b00}))
                                    : 32'hFFFF_FFFF;
  end

  typedef struct {
    int          inst;
    int          port;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  expGrant;
    int          expLat;
    logic [31:0] expRdata;
  } vec_t;

  vec_t vecs[11];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic ackOf(int i, int p);
    return (p == 0) ? m0Ack[i] : m1Ack[i];
  endfunction

  function automatic logic [31:0] rdOf(int i, int p);
    return (p == 0) ? m0Rdata[i] : m1Rdata[i];
  endfunction

  function automatic logic stallOf(int i, int p);
    return (p == 0) ? m0Stall[i] : m1Stall[i];
  endfunction

  task automatic driveReq(input int i, input int p, input logic req, input logic we,
                          input logic [31:0] a, input logic [31:0] d);
    if (p == 0) begin
      m0Req[i] = req; m0We[i] = we; m0Addr[i] = a; m0Wdata[i] = d;
    end else begin
      m1Req[i] = req; m1We[i] = we; m1Addr[i] = a; m1Wdata[i] = d;
    end
  endtask

  task automatic doReset();
    reset = 1'b0;
    for (int i = 0; i < N; i++) begin
      driveReq(i, 0, 1'b0, 1'b0, 32'h0, 32'h0);
      driveReq(i, 1, 1'b0, 1'b0, 32'h0, 32'h0);
      expRd[i][0] = 32'h0;
      expRd[i][1] = 32'h0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Called one delta past a rising edge with the DUT idle; cycle 0 is the first IDLE sample.
  task automatic applyStimulus(input int idx, input vec_t v);
    int    i, p, enCount;
    bit    seenAck;
    string pre;
    i = v.inst; p = v.port; enCount = 0; seenAck = 0;
    pre = $sformatf("v%0d", idx);
    driveReq(i, p, 1'b1, v.we, v.addr, v.wdata);
    for (int k = 0; k < 40 && !seenAck; k++) begin
      @(negedge clk);
      if (k == 0) checkOutput({pre, " stall"}, 32'(stallOf(i, p)), 32'd1);
      if (memEn[i]) begin
        enCount++;
        checkOutput({pre, " en_cycle"}, k, 32'd1);
        checkOutput({pre, " grant"}, 32'(grant[i]), 32'(v.expGrant));
        checkOutput({pre, " mem_we"}, 32'(memWe[i]), 32'(v.we));
        checkOutput({pre, " mem_addr"}, memAddr[i], v.addr);
        checkOutput({pre, " mem_wdata"}, memWdata[i], v.wdata);
      end
      if (ackOf(i, p)) begin
        seenAck = 1;
        checkOutput({pre, " ack_lat"}, k, v.expLat);
        checkOutput({pre, " rdata"}, rdOf(i, p), v.expRdata);
        checkOutput({pre, " other_rdata"}, rdOf(i, 1 - p), expRd[i][1 - p]);
        checkOutput({pre, " other_ack"}, 32'(ackOf(i, 1 - p)), 32'd0);
        checkOutput({pre, " stall_at_ack"}, 32'(stallOf(i, p)), 32'd0);
      end
      @(posedge clk);
      #1;
    end
    if (!seenAck) begin
      checks++; errors++;
      $display("[TB] FAIL %s ack_timeout: got no ack expected ack", pre);
    end
    driveReq(i, p, 1'b0, 1'b0, 32'h0, 32'h0);
    checkOutput({pre, " en_count"}, enCount, 32'd1);
    @(negedge clk);
    checkOutput({pre, " grant_idle"}, 32'(grant[i]), 32'd0);
    @(posedge clk);
    #1;
    expRd[i][p] = v.expRdata;
  endtask

  // Both ports held high through four transactions; expSeq holds the expected grants, oldest in the low bits.
  task automatic tieSequence(input int g, input logic [7:0] expSeq);
    bit         got;
    logic [1:0] eg;
    driveReq(g, 0, 1'b1, 1'b0, 32'h10, 32'h0);
    driveReq(g, 1, 1'b1, 1'b0, 32'h40, 32'h0);
    for (int t = 0; t < 4; t++) begin
      got = 0;
      eg  = expSeq[2*t +: 2];
      for (int k = 0; k < 30 && !got; k++) begin
        @(negedge clk);
        if (m0Ack[g] || m1Ack[g]) begin
          got = 1;
          checkOutput($sformatf("tie%0d_%0d grant", g, t), 32'(grant[g]), 32'(eg));
          checkOutput($sformatf("tie%0d_%0d acks", g, t), 32'({m1Ack[g], m0Ack[g]}), 32'(eg));
          if (eg == 2'b01) begin
            checkOutput($sformatf("tie%0d_%0d rdata", g, t), m0Rdata[g], 32'h8C08_0004);
            expRd[g][0] = 32'h8C08_0004;
          end else begin
            checkOutput($sformatf("tie%0d_%0d rdata", g, t), m1Rdata[g], 32'hA500_0040);
            expRd[g][1] = 32'hA500_0040;
          end
        end
      end
      if (!got) begin
        checks++; errors++;
        $display("[TB] FAIL tie%0d_%0d ack_timeout: got no ack expected ack", g, t);
      end
    end
    @(posedge clk);
    #1;
    driveReq(g, 0, 1'b0, 1'b0, 32'h0, 32'h0);
    driveReq(g, 1, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    checkOutput($sformatf("tie%0d grant_idle", g), 32'(grant[g]), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got no finish expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0]  = '{0, 0, 1'b0, 32'h10, 32'h0,         2'b01, 3,  32'h8C08_0004};
    vecs[1]  = '{0, 1, 1'b1, 32'h40, 32'hDEAD_BEEF, 2'b10, 3,  32'hA500_0040};
    vecs[2]  = '{0, 1, 1'b0, 32'h40, 32'h0,         2'b10, 3,  32'hDEAD_BEEF};
    vecs[3]  = '{0, 0, 1'b1, 32'h10, 32'h1234_5678, 2'b01, 3,  32'h8C08_0004};
    vecs[4]  = '{0, 0, 1'b0, 32'h10, 32'h0,         2'b01, 3,  32'h1234_5678};
    vecs[5]  = '{1, 0, 1'b0, 32'h20, 32'h0,         2'b01, 5,  32'hA500_0020};
    vecs[6]  = '{1, 1, 1'b1, 32'h24, 32'h0BAD_F00D, 2'b10, 5,  32'h0};
    vecs[7]  = '{1, 1, 1'b0, 32'h24, 32'h0,         2'b10, 5,  32'h0BAD_F00D};
    vecs[8]  = '{2, 0, 1'b0, 32'h10, 32'h0,         2'b01, 17, 32'h8C08_0004};
    vecs[9]  = '{2, 1, 1'b0, 32'h3C, 32'h0,         2'b10, 17, 32'hA500_003C};
    vecs[10] = '{3, 1, 1'b0, 32'h08, 32'h0,         2'b10, 3,  32'hA500_0008};

    doReset();
    for (int i = 0; i < N; i++) begin
      checkOutput($sformatf("rst%0d grant", i), 32'(grant[i]), 32'd0);
      checkOutput($sformatf("rst%0d mem_en", i), 32'(memEn[i]), 32'd0);
      checkOutput($sformatf("rst%0d mem_addr", i), memAddr[i], 32'h0);
      checkOutput($sformatf("rst%0d m0_rdata", i), m0Rdata[i], 32'h0);
    end

    tieSequence(0, 8'b10_01_10_01);
    tieSequence(3, 8'b01_01_01_01);

    for (int i = 0; i < 11; i++) applyStimulus(i, vecs[i]);

    // Changing the address after the IDLE sample must not reach the memory.
    driveReq(0, 0, 1'b1, 1'b0, 32'h10, 32'h0);
    @(posedge clk);
    #1;
    m0Addr[0] = 32'h20;
    begin
      bit got;
      got = 0;
      for (int k = 1; k < 20 && !got; k++) begin
        @(negedge clk);
        checkOutput($sformatf("stale c%0d mem_addr", k), memAddr[0], 32'h10);
        if (m0Ack[0]) begin
          got = 1;
          checkOutput("stale ack_lat", k, 32'd3);
          checkOutput("stale rdata", m0Rdata[0], 32'h1234_5678);
        end
      end
      if (!got) begin
        checks++; errors++;
        $display("[TB] FAIL stale ack_timeout: got no ack expected ack");
      end
    end
    @(posedge clk);
    #1;
    driveReq(0, 0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(posedge clk);
    #1;

    // Reset in the middle of WAIT drops the access; the still-pending request then completes afresh.
    driveReq(1, 0, 1'b1, 1'b0, 32'h20, 32'h0);
    @(negedge clk);
    @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("rstwait mem_en_issue", 32'(memEn[1]), 32'd1);
    @(posedge clk);
    #1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput("rstwait grant", 32'(grant[1]), 32'd0);
    checkOutput("rstwait mem_en", 32'(memEn[1]), 32'd0);
    checkOutput("rstwait ack", 32'(m0Ack[1]), 32'd0);
    checkOutput("rstwait rdata", m0Rdata[1], 32'h0);
    @(posedge clk);
    #1;
    checkOutput("rstwait ack_held", 32'(m0Ack[1]), 32'd0);
    checkOutput("rstwait stall_held", 32'(m0Stall[1]), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    begin
      bit got;
      got = 0;
      for (int k = 1; k < 30 && !got; k++) begin
        @(negedge clk);
        if (m0Ack[1]) begin
          got = 1;
          checkOutput("rstwait re_lat", k, 32'd5);
          checkOutput("rstwait re_rdata", m0Rdata[1], 32'hA500_0020);
        end
      end
      if (!got) begin
        checks++; errors++;
        $display("[TB] FAIL rstwait ack_timeout: got no ack expected ack");
      end
    end
    @(posedge clk);
    #1;
    driveReq(1, 0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    checkOutput("rstwait grant_idle", 32'(grant[1]), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
